efc_latch_load_ctl: RTL
=======================

Name: efc_latch_load_ctl

Overview:
- Sequencer that copies fuse-array words into a bank of transparent efuse shadow latches, one word per latch group.
- On a load request it:
  - reads fuse words 0..NUM_WORDS-1 in order;
  - registers each word onto the shared latch data bus;
  - pulses that word's latch control with setup and hold margin.
- Sits between the fuse array read port and the efuse latch bank. Consumers see busy/done status.

Parameters:
NUM_WORDS, 8, number of fuse words and latch groups; minimum 1
WORD_W, 32, bits per fuse word and latch group
ADDR_W, 3, fuse address width; 2**ADDR_W >= NUM_WORDS
RD_LAT, 2, cycles from fuse_rd_en to valid fuse_rdata; minimum 1
PULSE_W, 2, cycles lat_c stays high per word; minimum 1

Ports:
clk  input  1  clock
arst_l  input  1  asynchronous active-low reset
load_req  input  1  start a full load; sampled in IDLE or DONE only
fuse_rd_en  output  1  fuse read strobe, one cycle per word
fuse_addr  output  ADDR_W  fuse word address
fuse_rdata  input  WORD_W  fuse read data, valid RD_LAT cycles after fuse_rd_en
lat_d  output  WORD_W  shared latch data bus
lat_c  output  NUM_WORDS  one-hot latch controls; high = transparent
load_busy  output  1  load sequence in progress
load_done  output  1  sticky completion flag

Behaviour:
- Clock and reset: one clock (clk). Reset (arst_l) is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, word index 0. Reset asserted mid-load:
  - lat_c drops to 0 immediately, with no clock needed.
  - Latches keep whatever was loaded; a partial load is not flagged.
  - A fresh load_req is required after reset.
- All outputs are driven directly from flops. lat_c must be glitch-free.
- FSM states: IDLE, READ, WAIT, SETUP, OPEN, HOLD, DONE.
- IDLE or DONE with load_req=1 -> READ next cycle.
  - Word index is cleared to 0.
  - load_done clears and load_busy sets on the same edge.
- READ (1 cycle): fuse_rd_en=1, fuse_addr=index -> WAIT.
- WAIT (RD_LAT cycles, internal counter):
  - On the edge ending the last WAIT cycle, fuse_rdata is registered into lat_d.
  - Then -> SETUP.
- SETUP (1 cycle): lat_c=0, lat_d stable -> OPEN.
- OPEN (PULSE_W cycles): lat_c[index]=1, all other bits 0 -> HOLD.
- HOLD (1 cycle): lat_c=0, lat_d unchanged.
  - index < NUM_WORDS-1: index+1, -> READ.
  - Otherwise -> DONE. The index does not wrap.
- DONE: load_busy=0, load_done=1 until the next accepted load_req.
- fuse_addr holds its last value outside READ. fuse_rdata is ignored except at the WAIT capture edge.
- lat_d changes only at the WAIT capture edge, so never while any lat_c bit is high. lat_d holds its last word after DONE.
- Timing:
  - Cycles per word = 3 + RD_LAT + PULSE_W.
  - load_busy is high for NUM_WORDS*(3+RD_LAT+PULSE_W) cycles.
  - load_done rises on the edge leaving the final HOLD.
- load_req while busy is ignored and not queued. load_req held high continuously restarts a load from DONE immediately.
- NUM_WORDS=1: a single word pass, then DONE. The index stays 0.

Test Plan:
- Defaults. Fuse words = 0xA5A50000+n. One-cycle load_req.
  - load_busy is high 56 cycles; load_done rises at cycle 57 after the request.
  - lat_c pulses bit n for exactly 2 cycles, in order 0..7.
  - lat_d=0xA5A50000+n throughout each pulse, plus 1 cycle before and 1 cycle after.
- Sequence check.
  - fuse_rd_en fires 8 times with fuse_addr 0..7, spaced 7 cycles apart.
  - fuse_rdata is driven only in the RD_LAT window, X otherwise; no X ever reaches lat_d.
- Reset mid-load. Pulse arst_l low while lat_c[3]=1.
  - lat_c goes to 0 asynchronously; all outputs are 0.
  - With no new load_req over 20 cycles, the block stays IDLE.
- load_req asserted during the word-4 WAIT is ignored; total busy time is still 56 cycles.
- Restart from DONE:
  - load_req clears load_done on the next edge; a second full pass reloads new fuse values.
  - load_req held high continuously gives back-to-back loads with a 1-cycle DONE gap.
- Parameter corners.
  - NUM_WORDS=1, RD_LAT=1, PULSE_W=1: busy is 5 cycles; lat_c[0] is high for 1 cycle.
  - NUM_WORDS=5, ADDR_W=3: fuse_addr stops at 4 and never reaches 5.

Source files
------------

// File: rtl/efc_latch_load_ctl.sv
// efc_latch_load_ctl: copies fuse-array words, one at a time, into a bank of
// transparent efuse shadow latches through a shared data bus and one-hot
// latch controls, with setup and hold margin around every latch pulse.
module efc_latch_load_ctl #(
    parameter int NUM_WORDS = 8,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 3,
    parameter int RD_LAT    = 2,
    parameter int PULSE_W   = 2
) (
    input  logic                 clk,
    input  logic                 arst_l,
    input  logic                 load_req,
    output logic                 fuse_rd_en,
    output logic [ADDR_W-1:0]    fuse_addr,
    input  logic [WORD_W-1:0]    fuse_rdata,
    output logic [WORD_W-1:0]    lat_d,
    output logic [NUM_WORDS-1:0] lat_c,
    output logic                 load_busy,
    output logic                 load_done
);

    // One counter serves both the read-latency wait and the pulse width.
    localparam int CNT_MAX = (RD_LAT > PULSE_W) ? RD_LAT : PULSE_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  RD_LAST  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  PW_LAST  = CNT_W'(PULSE_W - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SETUP = 3'd3,
        ST_OPEN  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t                state_r;
    logic [ADDR_W-1:0]     idx_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  rd_en_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [WORD_W-1:0]     lat_d_r;
    logic [NUM_WORDS-1:0]  lat_c_r;
    logic                  busy_r;
    logic                  done_r;

    // Latch-control pattern for one word: only the selected group is opened.
    function automatic logic [NUM_WORDS-1:0] onehot_sel(input logic [ADDR_W-1:0] idx);
        logic [NUM_WORDS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            v[i] = (idx == ADDR_W'(i));
        end
        return v;
    endfunction

    // Load sequencer: every output is a flop so lat_c cannot glitch, and the
    // async clear drops any open latch control without needing a clock.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
            rd_en_r <= 1'b0;
            addr_r  <= '0;
            lat_d_r <= '0;
            lat_c_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (load_req) begin
                        state_r <= ST_READ;
                        idx_r   <= '0;
                        rd_en_r <= 1'b1;
                        addr_r  <= '0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        rd_en_r <= 1'b0;
                    end
                end
                ST_READ: begin
                    rd_en_r <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Fuse data is only looked at on the edge ending the wait.
                    if (cnt_r == RD_LAST) begin
                        lat_d_r <= fuse_rdata;
                        cnt_r   <= '0;
                        state_r <= ST_SETUP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_SETUP: begin
                    lat_c_r <= onehot_sel(idx_r);
                    cnt_r   <= '0;
                    state_r <= ST_OPEN;
                end
                ST_OPEN: begin
                    if (cnt_r == PW_LAST) begin
                        lat_c_r <= '0;
                        cnt_r   <= '0;
                        state_r <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // The index never wraps; the last word finishes the load.
                    if (idx_r < IDX_LAST) begin
                        idx_r   <= idx_r + ADDR_W'(1);
                        addr_r  <= idx_r + ADDR_W'(1);
                        rd_en_r <= 1'b1;
                        state_r <= ST_READ;
                    end else begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    // Unreachable encoding: close the latches and go idle.
                    state_r <= ST_IDLE;
                    rd_en_r <= 1'b0;
                    lat_c_r <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign fuse_rd_en = rd_en_r;
    assign fuse_addr  = addr_r;
    assign lat_d      = lat_d_r;
    assign lat_c      = lat_c_r;
    assign load_busy  = busy_r;
    assign load_done  = done_r;

endmodule
